// File: rtl/textgen.sv
// textgen: character-cell text renderer with a 4-cycle pixel pipeline, internal character RAM,
// host write port and clear-to-space engine. Define TEXTGEN_CURSOR_EN for a blinking underline cursor.
module textgen #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic        PIXCLK,
  input  logic        RST,
  input  logic [9:0]  XPOS,
  input  logic [9:0]  YPOS,
  input  logic        HS,
  input  logic        VS,
  input  logic        WR_EN,
  input  logic [11:0] WR_ADDR,
  input  logic [7:0]  WR_DATA,
  output logic        WR_READY,
  input  logic        CLR,
  input  logic [11:0] CUR_ADDR,
  output logic [11:0] FONT_ADDR,
  input  logic [7:0]  FONT_DATA,
  output logic        PIX,
  output logic        HS_O,
  output logic        VS_O
);

  localparam int          CELLS     = COLS * ROWS;
  localparam logic [11:0] LAST_CELL = 12'(CELLS - 1);
  localparam logic [9:0]  X_LIMIT   = 10'(COLS * 8);
  localparam logic [9:0]  Y_LIMIT   = 10'(ROWS * 16);
  localparam logic [7:0]  SPACE     = 8'h20;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      state;
  logic [11:0] clr_count;
  logic [7:0]  char_mem [CELLS];
  logic        mem_we;
  logic [11:0] mem_waddr;
  logic [7:0]  mem_wdata;

  logic        pix_active;
  logic [11:0] cell_addr;
  logic        cursor_hit;

  logic        s1_active, s2_active, s3_active;
  logic        s1_cursor, s2_cursor, s3_cursor;
  logic [11:0] s1_addr;
  logic [3:0]  s1_row, s2_row;
  logic [2:0]  s1_xbit, s2_xbit, s3_xbit;
  logic [7:0]  char_code;
  logic [3:0]  hs_pipe, vs_pipe;

  // Reset lands in CLEAR so the screen comes up blank without host help.
  always_ff @(posedge PIXCLK) begin
    if (RST) begin
      state     <= CLEAR;
      clr_count <= '0;
      WR_READY  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (CLR) begin
            state     <= CLEAR;
            clr_count <= '0;
            WR_READY  <= 1'b0;
          end
        end
        CLEAR: begin
          if (clr_count == LAST_CELL) begin
            state    <= IDLE;
            WR_READY <= 1'b1;
          end else begin
            clr_count <= clr_count + 12'd1;
          end
        end
      endcase
    end
  end

  // Out-of-range host writes are accepted by the handshake but never reach the RAM.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_count;
    mem_wdata = SPACE;
    if (!RST) begin
      if (state == CLEAR) begin
        mem_we = 1'b1;
      end else if (WR_EN && WR_READY && (WR_ADDR <= LAST_CELL)) begin
        mem_we    = 1'b1;
        mem_waddr = WR_ADDR;
        mem_wdata = WR_DATA;
      end
    end
  end

  always_ff @(posedge PIXCLK) begin
    if (mem_we) begin
      char_mem[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    pix_active = (XPOS != 10'h3FF) && (YPOS != 10'h3FF) && (XPOS < X_LIMIT) && (YPOS < Y_LIMIT);
    cell_addr  = 12'(YPOS[9:4]) * 12'(COLS) + 12'(XPOS[9:3]);
  end

`ifdef TEXTGEN_CURSOR_EN
  logic [4:0] frame_count;

  // vs_pipe[0] holds last cycle's VS, so this counts rising edges of the raw input.
  always_ff @(posedge PIXCLK) begin
    if (RST) begin
      frame_count <= '0;
    end else if (VS && !vs_pipe[0]) begin
      frame_count <= frame_count + 5'd1;
    end
  end

  assign cursor_hit = frame_count[4] && pix_active && (cell_addr == CUR_ADDR) && (YPOS[3:1] == 3'b111);
`else
  logic unused_cur_addr;
  assign unused_cur_addr = ^CUR_ADDR;
  assign cursor_hit      = 1'b0;
`endif

  // Blanking pixels read cell 0 so the RAM index always stays inside the array.
  always_ff @(posedge PIXCLK) begin
    if (RST) begin
      s1_active <= 1'b0;
      s1_cursor <= 1'b0;
      s1_addr   <= '0;
      s1_row    <= '0;
      s1_xbit   <= '0;
      s2_active <= 1'b0;
      s2_cursor <= 1'b0;
      s2_row    <= '0;
      s2_xbit   <= '0;
      char_code <= '0;
      s3_active <= 1'b0;
      s3_cursor <= 1'b0;
      s3_xbit   <= '0;
      PIX       <= 1'b0;
      hs_pipe   <= '0;
      vs_pipe   <= '0;
    end else begin
      s1_active <= pix_active;
      s1_cursor <= cursor_hit;
      s1_addr   <= pix_active ? cell_addr : 12'd0;
      s1_row    <= YPOS[3:0];
      s1_xbit   <= XPOS[2:0];

      s2_active <= s1_active;
      s2_cursor <= s1_cursor;
      s2_row    <= s1_row;
      s2_xbit   <= s1_xbit;
      char_code <= char_mem[s1_addr];

      s3_active <= s2_active;
      s3_cursor <= s2_cursor;
      s3_xbit   <= s2_xbit;

      PIX       <= (FONT_DATA[3'd7 - s3_xbit] ^ s3_cursor) & s3_active;
      hs_pipe   <= {hs_pipe[2:0], HS};
      vs_pipe   <= {vs_pipe[2:0], VS};
    end
  end

  assign FONT_ADDR = {char_code, s2_row};
  assign HS_O      = hs_pipe[3];
  assign VS_O      = vs_pipe[3];

endmodule

// File: tb/tb_textgen.sv
// Scoreboard bench for textgen: pixel stimulus pushes expectations, a monitor pops them at output time.
module tb_textgen;

  logic        PIXCLK;
  logic        RST;
  logic [9:0]  XPOS, YPOS;
  logic        HS, VS;
  logic        WR_EN;
  logic [11:0] WR_ADDR;
  logic [7:0]  WR_DATA;
  logic        WR_READY;
  logic        CLR;
  logic [11:0] CUR_ADDR;
  logic [11:0] FONT_ADDR;
  logic [7:0]  FONT_DATA;
  logic        PIX, HS_O, VS_O;

  typedef struct packed {
    logic        pix;
    logic        hs;
    logic        vs;
    logic        chk_fa;
    logic [11:0] fa;
  } exp_t;

  exp_t        pix_q[$];
  exp_t        fa_q[$];
  logic        drv_valid = 1'b0;
  logic [3:0]  vpipe = 4'b0;
  logic [7:0]  cells [2400];
  logic        cursor_on = 1'b0;
  int          total = 0;
  int          bad = 0;

  textgen dut (
    .PIXCLK(PIXCLK), .RST(RST), .XPOS(XPOS), .YPOS(YPOS), .HS(HS), .VS(VS),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_READY(WR_READY),
    .CLR(CLR), .CUR_ADDR(CUR_ADDR), .FONT_ADDR(FONT_ADDR), .FONT_DATA(FONT_DATA),
    .PIX(PIX), .HS_O(HS_O), .VS_O(VS_O)
  );

  initial PIXCLK = 1'b0;
  always #5 PIXCLK = ~PIXCLK;

  function automatic logic [7:0] font(input logic [11:0] a);
    if (a == 12'h410) return 8'h81;
    if (a == 12'h423) return 8'hC5;
    if (a[11:4] == 8'hFF) return 8'hFF;
    return 8'h00;
  endfunction

  // Registered font ROM: data one cycle after the address.
  always @(posedge PIXCLK) FONT_DATA <= font(FONT_ADDR);

  always @(posedge PIXCLK) vpipe <= {vpipe[2:0], drv_valid};

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: FONT_ADDR is presented two cycles after a pixel, PIX/syncs four cycles after.
  always @(negedge PIXCLK) begin
    exp_t e;
    if (vpipe[1]) begin
      if (fa_q.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL font_addr_queue: actual=empty required=entry");
      end else begin
        e = fa_q.pop_front();
        if (e.chk_fa) check_output("font_addr", 32'(FONT_ADDR), 32'(e.fa));
      end
    end
    if (vpipe[3]) begin
      if (pix_q.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL pix_queue: actual=empty required=entry");
      end else begin
        e = pix_q.pop_front();
        check_output("pix", 32'(PIX), 32'(e.pix));
        check_output("hs_o", 32'(HS_O), 32'(e.hs));
        check_output("vs_o", 32'(VS_O), 32'(e.vs));
      end
    end
  end

  function automatic exp_t mk(input logic p, input logic h, input logic v, input logic c, input logic [11:0] f);
    exp_t e;
    e.pix = p; e.hs = h; e.vs = v; e.chk_fa = c; e.fa = f;
    return e;
  endfunction

  task automatic apply_stimulus(input logic [9:0] x, input logic [9:0] y, input logic h, input logic v, input exp_t e);
    @(posedge PIXCLK); #1;
    XPOS = x; YPOS = y; HS = h; VS = v; drv_valid = 1'b1;
    pix_q.push_back(e);
    fa_q.push_back(e);
  endtask

  task automatic end_stream();
    @(posedge PIXCLK); #1;
    XPOS = 10'h3FF; YPOS = 10'h3FF; HS = 1'b0; VS = 1'b0; drv_valid = 1'b0;
    repeat (6) @(posedge PIXCLK);
  endtask

  // Expected pixel from the bench's own cell contents and font table.
  task automatic drive_pixel(input logic [9:0] x, input logic [9:0] y);
    logic       act;
    int         addr;
    logic [7:0] c;
    logic [7:0] g;
    logic       cur;
    act  = (x != 10'h3FF) && (y != 10'h3FF) && (x < 10'd640) && (y < 10'd480);
    addr = int'(y[9:4]) * 80 + int'(x[9:3]);
    c    = 8'h00;
    if (act) c = cells[addr];
    g    = font({c, y[3:0]});
    cur  = cursor_on && (addr == int'(CUR_ADDR)) && (y[3:1] == 3'b111);
    apply_stimulus(x, y, 1'b0, 1'b0, mk(act & (g[3'd7 - x[2:0]] ^ cur), 1'b0, 1'b0, act, {c, y[3:0]}));
  endtask

  task automatic scan_all();
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++)
        drive_pixel(10'(c * 8), 10'(r * 16));
    end_stream();
  endtask

  task automatic do_write(input logic [11:0] a, input logic [7:0] d, input logic c);
    @(posedge PIXCLK); #1;
    check_output("wr_ready_idle", 32'(WR_READY), 32'd1);
    WR_EN = 1'b1; WR_ADDR = a; WR_DATA = d; CLR = c;
    @(posedge PIXCLK); #1;
    WR_EN = 1'b0; CLR = 1'b0;
    if (a < 12'd2400) cells[a] = d;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (n < 5000) begin
      @(negedge PIXCLK);
      if (WR_READY) break;
      n++;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2400; i++) cells[i] = 8'h20;
  endtask

  task automatic pulse_vs(input int count);
    for (int i = 0; i < count; i++) begin
      @(posedge PIXCLK); #1; VS = 1'b1;
      @(posedge PIXCLK); #1; VS = 1'b0;
    end
    repeat (2) @(posedge PIXCLK);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         n;
    logic [7:0] glyph;
    RST = 1'b1; XPOS = 10'h3FF; YPOS = 10'h3FF; HS = 1'b0; VS = 1'b0;
    WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0; CLR = 1'b0; CUR_ADDR = 12'd0;

    repeat (2) @(posedge PIXCLK);
    @(negedge PIXCLK);
    check_output("rst_pix", 32'(PIX), 32'd0);
    check_output("rst_hs_o", 32'(HS_O), 32'd0);
    check_output("rst_vs_o", 32'(VS_O), 32'd0);
    check_output("rst_wr_ready", 32'(WR_READY), 32'd0);
    check_output("rst_font_addr", 32'(FONT_ADDR), 32'd0);
    @(posedge PIXCLK); #1;
    RST = 1'b0;
    wait_ready(n);
    check_output("reset_clear_len", 32'(n), 32'd2400);
    model_clear();
    scan_all();

    $display("[TB] glyph render");
    do_write(12'd0, 8'h41, 1'b0);
    glyph = 8'b1000_0001;
    for (int i = 0; i < 8; i++)
      apply_stimulus(10'(i), 10'd0, 1'b0, 1'b0, mk(glyph[7 - i], 1'b0, 1'b0, 1'b1, 12'h410));
    end_stream();
    do_write(12'd81, 8'h42, 1'b0);
    glyph = 8'b1100_0101;
    for (int i = 0; i < 8; i++)
      apply_stimulus(10'(8 + i), 10'd19, 1'b0, 1'b0, mk(glyph[7 - i], 1'b0, 1'b0, 1'b1, 12'h423));
    end_stream();

    $display("[TB] sync alignment");
    for (int line = 0; line < 4; line++)
      for (int c = 0; c < 200; c++)
        apply_stimulus(10'h3FF, 10'h3FF, (c >= 100 && c < 196), (line == 1 || line == 2),
                       mk(1'b0, (c >= 100 && c < 196), (line == 1 || line == 2), 1'b0, 12'h000));
    end_stream();

    $display("[TB] blanking and range");
    do_write(12'd80, 8'hFF, 1'b0);
    for (int i = 0; i < 8; i++)
      apply_stimulus(10'(i), 10'd16, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b1, 12'hFF0));
    for (int i = 0; i < 8; i++)
      apply_stimulus(10'(640 + i), 10'd0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 12'h000));
    apply_stimulus(10'h3FF, 10'd16, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 12'h000));
    apply_stimulus(10'd0, 10'd480, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 12'h000));
    apply_stimulus(10'd0, 10'h3FF, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 12'h000));
    end_stream();
    do_write(12'd2400, 8'h41, 1'b0);
    scan_all();

    $display("[TB] collision and clear");
    do_write(12'd5, 8'h42, 1'b1);
    check_output("wr_ready_drop", 32'(WR_READY), 32'd0);
    fork
      begin
        n = 0;
        while (n < 5000) begin
          @(negedge PIXCLK);
          if (WR_READY) break;
          n++;
          CLR = (n == 1000);
        end
        CLR = 1'b0;
      end
      begin
        apply_stimulus(10'd40, 10'd0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b1, 12'h420));
        apply_stimulus(10'd41, 10'd0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b1, 12'h420));
        end_stream();
      end
    join
    check_output("clr_ignored_len", 32'(n), 32'd2400);
    model_clear();
    scan_all();

    $display("[TB] reset mid-clear");
    do_write(12'd2399, 8'h41, 1'b0);
    @(posedge PIXCLK); #1; CLR = 1'b1;
    @(posedge PIXCLK); #1; CLR = 1'b0;
    repeat (999) @(posedge PIXCLK);
    #1 RST = 1'b1;
    @(posedge PIXCLK); #1;
    RST = 1'b0;
    wait_ready(n);
    check_output("restart_clear_len", 32'(n), 32'd2400);
    model_clear();
    scan_all();

`ifdef TEXTGEN_CURSOR_EN
    $display("[TB] cursor");
    pulse_vs(16);
    cursor_on = 1'b1;
    for (int y = 13; y < 16; y++)
      for (int x = 0; x < 8; x++)
        drive_pixel(10'(x), 10'(y));
    end_stream();
    pulse_vs(16);
    cursor_on = 1'b0;
    for (int y = 13; y < 16; y++)
      for (int x = 0; x < 8; x++)
        drive_pixel(10'(x), 10'(y));
    end_stream();
`endif

    repeat (4) @(posedge PIXCLK);
    check_output("pix_q_drained", 32'(pix_q.size()), 32'd0);
    check_output("fa_q_drained", 32'(fa_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/textgen.md
# textgen

Character-cell text renderer sitting directly downstream of the video sync generator. Consumes per-pixel XPOS/YPOS/HS/VS, looks up each cell's character code in an internal dual-port character RAM and its glyph row in an external registered font ROM, and emits a 1-bit pixel with matching delayed syncs. A host-side write port fills the character RAM. A clear engine blanks the RAM to spaces.

## Interface
- COLS, 80: character columns; cells are 8 pixels wide.
- ROWS, 30: character rows; cells are 16 pixels tall. COLS*ROWS ≤ 4096.

- PIXCLK  in  1  pixel clock; sole clock.
- RST  in  1  synchronous, active-high reset.
- XPOS  in  10  pixel column from sync generator; 10'h3FF = blanking.
- YPOS  in  10  pixel row; 10'h3FF = blanking.
- HS  in  1  horizontal sync, in phase with XPOS.
- VS  in  1  vertical sync, in phase with YPOS.
- WR_EN  in  1  write request.
- WR_ADDR  in  12  cell index = row*COLS + col.
- WR_DATA  in  8  character code.
- WR_READY  out  1  write accepted when WR_EN && WR_READY.
- CLR  in  1  start clear-to-space.
- CUR_ADDR  in  12  cursor cell index; ignored unless TEXTGEN_CURSOR_EN.
- FONT_ADDR  out  12  {char[7:0], glyph_row[3:0]} to font ROM.
- FONT_DATA  in  8  glyph row, valid 1 cycle after FONT_ADDR; bit 7 = leftmost pixel.
- PIX  out  1  pixel on/off.
- HS_O  out  1  HS delayed to align with PIX.
- VS_O  out  1  VS delayed to align with PIX.

## Operation
- Active pixel: XPOS != 3FF, YPOS != 3FF, XPOS < COLS*8, YPOS < ROWS*16. Otherwise PIX = 0.
- Read address = YPOS[9:4]*COLS + XPOS[9:3], 12-bit unsigned, no overflow for legal parameters.
- Character RAM: COLS*ROWS x 8, one synchronous write port and one synchronous read port, read-first on same-address collision (old data returned).
- Control FSM, two states:
  - IDLE: WR_READY = 1. Accepted write stores WR_DATA at WR_ADDR; WR_ADDR ≥ COLS*ROWS is accepted and dropped. CLR = 1 → CLEAR, counter = 0.
  - CLEAR: WR_READY = 0. Writes 8'h20 to the counter address each cycle and increments it; after COLS*ROWS-1 → IDLE. CLR is ignored. Host writes are not accepted.
- CLR and an accepted write in the same IDLE cycle: the write lands, then the clear overwrites it.
- Reset: FSM → CLEAR with counter 0, so the screen is blank after reset. RST mid-clear restarts from 0.

## Timing
- Pipeline latency: 4 PIXCLK cycles from XPOS/YPOS/HS/VS to PIX/HS_O/VS_O. Syncs are a pure 4-stage shift and keep pulse widths exactly.
  - Edge 1: inputs, active flag and RAM address registered.
  - Edge 2: RAM data registered. FONT_ADDR is driven combinationally from it plus YPOS[3:0] of that pixel.
  - Edge 3: FONT_DATA valid.
  - Edge 4: PIX = FONT_DATA[7 - XPOS[2:0]] & active, registered.
- Reset values, held while RST = 1 and for the first cycle after release: PIX 0, HS_O 0, VS_O 0, FONT_ADDR 0, WR_READY 0. All pipeline registers clear to 0.
- WR_READY drops the cycle after CLR is sampled in IDLE. It rises on the cycle after the final clear write.
- A full clear takes COLS*ROWS cycles (2400 at defaults).

## Configuration
- TEXTGEN_CURSOR_EN defined:
  - A 5-bit frame counter increments on each VS input rising edge and resets to 0.
  - When counter[4] = 1, glyph rows 14 and 15 of cell CUR_ADDR have PIX inverted, active pixels only.
  - The cursor match and row test are pipelined so PIX latency stays 4 cycles.
- Not defined: no counter and no inversion. CUR_ADDR is unused and the port remains.

## Test plan
- Reset and clear: RST high 3 cycles → PIX/HS_O/VS_O/WR_READY = 0. WR_READY stays 0 for 2400 cycles after release, then 1. Scanning all cells yields FONT_ADDR[11:4] = 8'h20.
- Glyph render: write 8'h41 to address 0, font model returns 8'h81 for 12'h410, drive YPOS = 0 and XPOS = 0..7 → FONT_ADDR = 12'h410, and PIX = 1,0,0,0,0,0,0,1 starting 4 cycles after XPOS = 0.
- Sync alignment: 96-cycle HS pulse and 2-line VS pulse → HS_O/VS_O identical, delayed exactly 4 cycles, aligned to PIX.
- Blanking and range: XPOS = 3FF or XPOS = 640 over a cell holding 0xFF glyphs → PIX = 0. Write to WR_ADDR = 2400 is accepted and no cell changes.
- Collision and clear: CLR with WR_EN in the same IDLE cycle → that write lands, WR_READY = 0 next cycle, cell reads 8'h20 after the clear. CLR during CLEAR is ignored (total 2400 cycles). RST at clear cycle 1000 → clear restarts and WR_READY stays 0 for 2400 cycles.
- TEXTGEN_CURSOR_EN: CUR_ADDR = 0, space glyph all-zero → after the 16th VS rising edge, YPOS = 14 and 15 with XPOS 0..7 give PIX = 1. After the 32nd edge, PIX = 0.
